// File: rtl/pipelined_regfile.sv
// Two-read / one-write register file with same-cycle write forwarding and a
// per-register pending scoreboard for read-after-write hazard detection.
module pipelined_regfile #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_IDX0 = 10,
    parameter int INIT_VAL0 = 15,
    parameter int INIT_IDX1 = 11,
    parameter int INIT_VAL1 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    input  logic              EnableWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reserve_en,
    input  logic [ADDR_W-1:0] reserve_reg,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pend_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = ADDR_W + 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [CNT_W-1:0]    count_next;

    logic wr_ok;
    logic rsv_ok;

    logic [ADDR_W-1:0] rd_idx  [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];
    logic              rd_fwd  [2];

    function automatic logic [DATA_W-1:0] reset_val(input int idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx == INIT_IDX0) v = DATA_W'(INIT_VAL0);
        if (idx == INIT_IDX1) v = DATA_W'(INIT_VAL1);
        return v;
    endfunction

    // Index 0 neither accepts data nor becomes pending when it is hardwired.
    assign wr_ok  = EnableWrite && !((ZERO_REG != 0) && (write_reg == '0));
    assign rsv_ok = reserve_en && !((ZERO_REG != 0) && (reserve_reg == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reset_val(i);
            end
        end else if (wr_ok) begin
            regs[write_reg] <= write_data;
        end
    end

    // Reserve is applied after the writeback clear so a new producer wins.
    always_comb begin
        pending_next = pending;
        if (wr_ok) begin
            pending_next[write_reg] = 1'b0;
        end
        if (rsv_ok) begin
            pending_next[reserve_reg] = 1'b1;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + CNT_W'(pending_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending    <= pending_next;
            pend_count <= count_next;
        end
    end

    assign rd_idx[0] = read_reg1;
    assign rd_idx[1] = read_reg2;

    // Forwarding is suppressed while reset is asserted so reads show reset contents.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_fwd[p]  = (BYPASS != 0) && !rst && wr_ok && (write_reg == rd_idx[p]);
            rd_data[p] = regs[rd_idx[p]];
            if ((ZERO_REG != 0) && (rd_idx[p] == '0)) begin
                rd_data[p] = '0;
            end
            if (rd_fwd[p]) begin
                rd_data[p] = write_data;
            end
            rd_busy[p] = pending[rd_idx[p]] && !rd_fwd[p];
        end
    end

    assign data_out1 = rd_data[0];
    assign data_out2 = rd_data[1];
    assign busy1     = rd_busy[0];
    assign busy2     = rd_busy[1];

endmodule

// File: doc/pipelined_regfile.md
Name: pipelined_regfile

Overview:
Parametrised, clocked general-purpose register file for the pipelined datapath. It replaces the level-sensitive 32x32 file and provides two read ports and one write port. The write port forwards into the reads in the same cycle, and register 0 is hardwired to zero. A per-register pending scoreboard lets the issue stage detect read-after-write hazards. The block sits between decode/issue (read, reserve) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and ignores reservations
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
INIT_IDX0, 10, index loaded with INIT_VAL0 at reset
INIT_VAL0, 15, reset value of register INIT_IDX0
INIT_IDX1, 11, index loaded with INIT_VAL1 at reset
INIT_VAL1, 10, reset value of register INIT_IDX1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
read_reg1  in  ADDR_W  read port 1 index
read_reg2  in  ADDR_W  read port 2 index
data_out1  out  DATA_W  read port 1 data (combinational)
data_out2  out  DATA_W  read port 2 data (combinational)
EnableWrite  in  1  write enable, sampled on clk rise
write_reg  in  ADDR_W  write index
write_data  in  DATA_W  write data
reserve_en  in  1  mark reserve_reg pending (issue of a producer)
reserve_reg  in  ADDR_W  index to reserve
busy1  out  1  read_reg1 has an outstanding producer
busy2  out  1  read_reg2 has an outstanding producer
pend_count  out  ADDR_W+1  number of registers currently pending

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset (rst=1, asynchronous):
  - All registers clear to 0, except reg[INIT_IDX0]=INIT_VAL0 and reg[INIT_IDX1]=INIT_VAL1.
  - All pending bits clear; pend_count=0.
  - Outputs during reset: data_outN = reset contents of the addressed register; busyN = 0.
  - Reset asserted mid-operation discards any write or reservation in that cycle.
- Write:
  - When EnableWrite=1 at a clk rise, reg[write_reg] <= write_data.
  - Writes to index 0 are dropped when ZERO_REG=1.
- Read (combinational, zero latency):
  - data_outN = reg[read_regN], or 0 when ZERO_REG=1 and read_regN=0.
  - With BYPASS=1, EnableWrite=1 and write_reg=read_regN (nonzero, or any index if ZERO_REG=0), data_outN = write_data in the same cycle.
  - Both read ports are independent; both may address the same register.
- Scoreboard (pending[NUM_REGS], registered):
  - reserve_en=1 at a clk rise sets pending[reserve_reg].
  - EnableWrite=1 at a clk rise clears pending[write_reg].
  - Same index reserved and written in the same cycle: pending ends SET, because the new producer wins. The data write still occurs.
  - Reserving an already-pending register leaves it set, with no double count.
  - Writing a non-pending register leaves pending unchanged, with no underflow.
  - Index 0 is never pending when ZERO_REG=1.
- busyN = pending[read_regN], except 0 when the same-cycle write to read_regN has BYPASS=1, because the data is forwarded. This holds even if a simultaneous reserve targets read_regN.
- pend_count = population count of pending, registered, updated on the same edge as pending. The range is 0..NUM_REGS, so the width is ADDR_W+1.
- No X propagation: the outputs are defined for every input combination after reset.

Test Plan:
1. Reset with rst=1, then release -> data_out1(read_reg1=10)=15, data_out2(read_reg2=11)=10, every other index reads 0, busy1=busy2=0, pend_count=0.
2. Write reg5=0xDEADBEEF with read_reg1=5 in the same cycle -> data_out1=0xDEADBEEF before the edge (bypass). After the edge with EnableWrite=0 it still reads 0xDEADBEEF. Write reg0=0x1234 -> reg0 reads 0.
3. Reserve reg7 -> next cycle busy1(read_reg1=7)=1, pend_count=1. Write reg7=0x55 -> busy1=0 in the write cycle, then pending clears and pend_count=0.
4. In one cycle, reserve reg9 and write reg9=0xAA -> after the edge, pending[9]=1, pend_count=1, data_out reads 0xAA.
5. Reserve reg3 twice, then write reg4 (not pending) -> pend_count stays 1 and never underflows. Reserve reg0 -> pend_count unchanged.
6. Reserve reg12 and reg13, then assert rst between clock edges -> pending clears immediately, pend_count=0, reg10/reg11 return to 15/10, other registers 0.
